// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial bit stream, run-time config and match outputs of the pattern detector
interface seq_detect_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  logic             din;
  logic             din_vld;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             cfg_load;
  logic             cnt_clr;
  logic             match;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;
  modport master (output din, din_vld, cfg_pat, cfg_len, cfg_ovl, cfg_load, cnt_clr,
                  input match, armed, match_cnt);
  modport slave  (input din, din_vld, cfg_pat, cfg_len, cfg_ovl, cfg_load, cnt_clr,
                  output match, armed, match_cnt);
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable serial pattern detector with overlap mode and saturating match counter
module seq_detect_param #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0010_1010,
  parameter int               RST_LEN = 6,
  parameter int               RST_OVL = 1
) (
  input logic             clk,
  input logic             rst,
  seq_detect_param_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] RST_LEN_C = (RST_LEN > PAT_W) ? LEN_W'(PAT_W) : LEN_W'(RST_LEN);
  logic [PAT_W-1:0] pat_r, hist, hist_nx, mask;
  logic [LEN_W-1:0] len_r, fill, fill_inc, fill_nx;
  logic             ovl_r, hit;
  always_comb begin
    hist_nx  = {hist[PAT_W-2:0], bus.din};
    fill_inc = (fill == len_r) ? fill : fill + 1'b1;
    mask     = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_r));
    // only the low len_r bits of the window take part in the compare
    hit      = bus.din_vld && !bus.cfg_load && (len_r != '0) && (fill_inc == len_r) &&
               (((hist_nx ^ pat_r) & mask) == '0);
    fill_nx  = (hit && !ovl_r) ? '0 : fill_inc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r         <= RST_PAT;
      len_r         <= RST_LEN_C;
      ovl_r         <= 1'(RST_OVL);
      hist          <= '0;
      fill          <= '0;
      bus.match     <= 1'b0;
      bus.armed     <= 1'b0;
      bus.match_cnt <= '0;
    end else begin
      bus.match <= hit;
      if (bus.cfg_load) begin
        pat_r     <= bus.cfg_pat;
        len_r     <= (bus.cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.cfg_len;
        ovl_r     <= bus.cfg_ovl;
        hist      <= '0;
        fill      <= '0;
        bus.armed <= 1'b0;
      end else if (bus.din_vld) begin
        hist      <= hist_nx;
        fill      <= fill_nx;
        bus.armed <= (len_r != '0) && (fill_nx == len_r);
      end
      // clear wins over a coincident hit; the hit still pulses match
      if (bus.cnt_clr) bus.match_cnt <= '0;
      else if (hit && bus.match_cnt != '1) bus.match_cnt <= bus.match_cnt + 1'b1;
    end
  end
endmodule
